// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode: a circular buffer of
// {pc, instr} pairs with valid/ready handshakes and a wrong-path flush.
module fetch_queue #(
    parameter int unsigned N     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_valid_F,
    input  logic [N-1:0]               enq_pc_F,
    input  logic [31:0]                enq_instr_F,
    output logic                       enq_ready_F,
    output logic                       deq_valid_D,
    output logic [N-1:0]               deq_pc_D,
    output logic [31:0]                deq_instr_D,
    input  logic                       deq_ready_D,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = N + 32;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          enq_fire_c;
    logic          deq_fire_c;
    logic [EW-1:0] head_c;

    // Handshake qualifiers; flush masks both sides for the whole cycle
    assign enq_ready_F = (count_q != CW'(DEPTH)) & ~flush;
    assign deq_valid_D = (count_q != '0) & ~flush;
    assign enq_fire_c  = enq_valid_F & enq_ready_F;
    assign deq_fire_c  = deq_valid_D & deq_ready_D;

    assign head_c      = mem_q[rd_ptr_q];
    assign deq_pc_D    = head_c[EW-1:32];
    assign deq_instr_D = head_c[31:0];
    assign count       = count_q;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire_c) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq_fire_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({enq_fire_c, deq_fire_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared only by reset; a flush just abandons the contents
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (enq_fire_c) begin
            mem_q[wr_ptr_q] <= {enq_pc_F, enq_instr_F};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/drain, streaming wrap,
// full-with-dequeue, flush and reset-during-operation scenarios.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid_F;
    logic [63:0] enq_pc_F;
    logic [31:0] enq_instr_F;
    logic        enq_ready_F;
    logic        deq_valid_D;
    logic [63:0] deq_pc_D;
    logic [31:0] deq_instr_D;
    logic        deq_ready_D;
    logic        flush;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;

    fetch_queue #(.N(64), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enq_valid_F (enq_valid_F),
        .enq_pc_F    (enq_pc_F),
        .enq_instr_F (enq_instr_F),
        .enq_ready_F (enq_ready_F),
        .deq_valid_D (deq_valid_D),
        .deq_pc_D    (deq_pc_D),
        .deq_instr_D (deq_instr_D),
        .deq_ready_D (deq_ready_D),
        .flush       (flush),
        .count       (count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return 32'h1300_0013 ^ pc[31:0];
    endfunction

    task automatic set_enq(input logic v, input logic [63:0] pc);
        enq_valid_F = v;
        enq_pc_F    = pc;
        enq_instr_F = instr_of(pc);
    endtask

    // Advance one cycle: through the rising edge, back to the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Enqueue n entries from base with decode stalled; ends at a negedge
    task automatic fill(input logic [63:0] base, input int n);
        deq_ready_D = 1'b0;
        for (int i = 0; i < n; i++) begin
            set_enq(1'b1, base + 64'(4 * i));
            step();
        end
        set_enq(1'b0, 64'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; deq_ready_D = 1'b0;
        set_enq(1'b1, 64'h40);
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        set_enq(1'b0, 64'h0);
        #1;
        total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
        total++; if (deq_valid_D !== 1'b0) $display("FAIL reset_deq_valid: got %b expected 0", deq_valid_D); else passed++;
        total++; if (deq_pc_D !== 64'h0) $display("FAIL reset_deq_pc: got %h expected 0", deq_pc_D); else passed++;
        total++; if (deq_instr_D !== 32'h0) $display("FAIL reset_deq_instr: got %h expected 0", deq_instr_D); else passed++;
        total++; if (enq_ready_F !== 1'b1) $display("FAIL reset_enq_ready: got %b expected 1", enq_ready_F); else passed++;
    endtask

    task automatic test_fill_drain();
        deq_ready_D = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_enq(1'b1, 64'(4 * i));
            #1;
            total++; if (enq_ready_F !== 1'b1) $display("FAIL fill_ready%0d: got %b expected 1", i, enq_ready_F); else passed++;
            step();
        end
        set_enq(1'b1, 64'h10);
        #1;
        total++; if (count !== 3'd4) $display("FAIL fill_count: got %0d expected 4", count); else passed++;
        total++; if (enq_ready_F !== 1'b0) $display("FAIL fill_full_ready: got %b expected 0", enq_ready_F); else passed++;
        step();
        set_enq(1'b0, 64'h0);
        deq_ready_D = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (deq_valid_D !== 1'b1) $display("FAIL drain_valid%0d: got %b expected 1", i, deq_valid_D); else passed++;
            total++; if (deq_pc_D !== 64'(4 * i)) $display("FAIL drain_pc%0d: got %h expected %h", i, deq_pc_D, 64'(4 * i)); else passed++;
            total++; if (deq_instr_D !== instr_of(64'(4 * i))) $display("FAIL drain_instr%0d: got %h expected %h", i, deq_instr_D, instr_of(64'(4 * i))); else passed++;
            step();
        end
        #1;
        total++; if (count !== 3'd0) $display("FAIL drain_count: got %0d expected 0", count); else passed++;
        total++; if (deq_valid_D !== 1'b0) $display("FAIL drain_empty_valid: got %b expected 1'b0", deq_valid_D); else passed++;
        deq_ready_D = 1'b0;
    endtask

    task automatic test_streaming();
        deq_ready_D = 1'b1;
        for (int j = 0; j <= 20; j++) begin
            if (j < 20) set_enq(1'b1, 64'h100 + 64'(4 * j));
            else        set_enq(1'b0, 64'h0);
            #1;
            if (j == 0) begin
                total++; if (deq_valid_D !== 1'b0) $display("FAIL stream_nopass: got %b expected 0", deq_valid_D); else passed++;
            end else begin
                total++; if (deq_valid_D !== 1'b1 || deq_pc_D !== 64'h100 + 64'(4 * (j - 1)))
                    $display("FAIL stream_pc%0d: got valid %b pc %h expected 1 %h", j, deq_valid_D, deq_pc_D, 64'h100 + 64'(4 * (j - 1)));
                else passed++;
                total++; if (count !== 3'd1) $display("FAIL stream_count%0d: got %0d expected 1", j, count); else passed++;
            end
            step();
        end
        #1;
        total++; if (count !== 3'd0) $display("FAIL stream_end_count: got %0d expected 0", count); else passed++;
        deq_ready_D = 1'b0;
    endtask

    task automatic test_full_deq();
        fill(64'h300, 4);
        set_enq(1'b1, 64'h310);
        deq_ready_D = 1'b1;
        #1;
        total++; if (count !== 3'd4) $display("FAIL fulldeq_count: got %0d expected 4", count); else passed++;
        total++; if (enq_ready_F !== 1'b0) $display("FAIL fulldeq_ready: got %b expected 0", enq_ready_F); else passed++;
        total++; if (deq_pc_D !== 64'h300) $display("FAIL fulldeq_head: got %h expected 300", deq_pc_D); else passed++;
        step();
        set_enq(1'b0, 64'h0);
        deq_ready_D = 1'b0;
        #1;
        total++; if (count !== 3'd3) $display("FAIL fulldeq_count_after: got %0d expected 3", count); else passed++;
        total++; if (enq_ready_F !== 1'b1) $display("FAIL fulldeq_ready_after: got %b expected 1", enq_ready_F); else passed++;
        deq_ready_D = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            total++; if (deq_pc_D !== 64'h300 + 64'(4 * i)) $display("FAIL fulldeq_drain%0d: got %h expected %h", i, deq_pc_D, 64'h300 + 64'(4 * i)); else passed++;
            step();
        end
        #1;
        total++; if (count !== 3'd0) $display("FAIL fulldeq_no_310: got count %0d expected 0", count); else passed++;
        deq_ready_D = 1'b0;
    endtask

    task automatic test_flush();
        fill(64'h200, 4);
        flush = 1'b1;
        set_enq(1'b1, 64'h210);
        deq_ready_D = 1'b1;
        #1;
        total++; if (enq_ready_F !== 1'b0) $display("FAIL flush_enq_ready: got %b expected 0", enq_ready_F); else passed++;
        total++; if (deq_valid_D !== 1'b0) $display("FAIL flush_deq_valid: got %b expected 0", deq_valid_D); else passed++;
        step();
        flush = 1'b0;
        deq_ready_D = 1'b0;
        set_enq(1'b1, 64'hD800);
        #1;
        total++; if (count !== 3'd0) $display("FAIL flush_count: got %0d expected 0", count); else passed++;
        total++; if (enq_ready_F !== 1'b1) $display("FAIL flush_ready_after: got %b expected 1", enq_ready_F); else passed++;
        step();
        set_enq(1'b0, 64'h0);
        deq_ready_D = 1'b1;
        #1;
        total++; if (deq_valid_D !== 1'b1 || deq_pc_D !== 64'hD800) $display("FAIL flush_vector_pc: got valid %b pc %h expected 1 d800", deq_valid_D, deq_pc_D); else passed++;
        total++; if (deq_instr_D !== instr_of(64'hD800)) $display("FAIL flush_vector_instr: got %h expected %h", deq_instr_D, instr_of(64'hD800)); else passed++;
        step();
        // Partial queue: flush must also suppress a concurrent enqueue and dequeue
        fill(64'h500, 2);
        flush = 1'b1;
        deq_ready_D = 1'b1;
        set_enq(1'b1, 64'h508);
        step();
        flush = 1'b0;
        set_enq(1'b1, 64'h600);
        deq_ready_D = 1'b0;
        #1;
        total++; if (count !== 3'd0) $display("FAIL flush_partial_count: got %0d expected 0", count); else passed++;
        step();
        set_enq(1'b0, 64'h0);
        #1;
        total++; if (count !== 3'd1 || deq_pc_D !== 64'h600) $display("FAIL flush_partial_head: got count %0d pc %h expected 1 600", count, deq_pc_D); else passed++;
        deq_ready_D = 1'b1;
        step();
        deq_ready_D = 1'b0;
    endtask

    task automatic test_reset_mid();
        fill(64'h700, 3);
        #1;
        total++; if (count !== 3'd3) $display("FAIL rstmid_pre_count: got %0d expected 3", count); else passed++;
        reset = 1'b1;
        flush = 1'b1;
        set_enq(1'b1, 64'h70C);
        step();
        reset = 1'b0;
        flush = 1'b0;
        set_enq(1'b1, 64'h800);
        #1;
        total++; if (count !== 3'd0) $display("FAIL rstmid_count: got %0d expected 0", count); else passed++;
        total++; if (deq_pc_D !== 64'h0 || deq_instr_D !== 32'h0) $display("FAIL rstmid_storage: got pc %h instr %h expected 0 0", deq_pc_D, deq_instr_D); else passed++;
        step();
        set_enq(1'b0, 64'h0);
        #1;
        total++; if (count !== 3'd1 || deq_valid_D !== 1'b1 || deq_pc_D !== 64'h800)
            $display("FAIL rstmid_resume: got count %0d valid %b pc %h expected 1 1 800", count, deq_valid_D, deq_pc_D);
        else passed++;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; deq_ready_D = 1'b0;
        set_enq(1'b0, 64'h0);
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_deq();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the fetch stage and decode in the 64-bit pipelined core. Buffers up to DEPTH {PC, instruction} pairs produced by fetch and hands them to decode over a valid/ready handshake. Decouples fetch from decode stalls and discards all buffered wrong-path instructions when a branch is taken or an exception vector is loaded.

## Interface
- N, 64, PC width in bits
- DEPTH, 4, queue entries; power of two, ≥ 2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enq_valid_F  in  1  fetch presents a fetched instruction this cycle
- enq_pc_F  in  N  PC of the presented instruction (fetch's imem address)
- enq_instr_F  in  32  instruction word read from imem at enq_pc_F
- enq_ready_F  out  1  queue accepts an entry; fetch holds its PC when low
- deq_valid_D  out  1  head entry is valid for decode
- deq_pc_D  out  N  PC of head entry
- deq_instr_D  out  32  instruction of head entry
- deq_ready_D  in  1  decode consumes the head entry this cycle
- flush  in  1  taken branch or exception vector load; discard all entries
- count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Circular buffer of DEPTH entries, each {pc[N-1:0], instr[31:0]}; write pointer wr_ptr, read pointer rd_ptr, both $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy register count.
- enq_ready_F = (count != DEPTH) & ~flush. Does not depend on deq_ready_D; no enqueue into a full queue, even if a dequeue occurs in the same cycle.
- deq_valid_D = (count != 0) & ~flush. deq_pc_D/deq_instr_D = storage[rd_ptr], combinational read; stable while deq_valid_D is high and deq_ready_D is low.
- Enqueue fires when enq_valid_F & enq_ready_F: storage[wr_ptr] ← {enq_pc_F, enq_instr_F}; wr_ptr += 1.
- Dequeue fires when deq_valid_D & deq_ready_D: rd_ptr += 1.
- count next = count + enq_fire − deq_fire; both firing in one cycle leaves count unchanged.
- Flush (highest priority below reset): wr_ptr, rd_ptr, count ← 0; an enqueue or dequeue in the flush cycle does not fire; storage contents are left as is (don't-care).
- Reset: wr_ptr, rd_ptr, count ← 0; all storage entries ← 0. Reset overrides flush and all handshakes.
- No pass-through: an entry written into an empty queue is not visible at deq_* in the same cycle.

## Timing
- Reset values: count = 0, deq_valid_D = 0, deq_pc_D = 0, deq_instr_D = 0, enq_ready_F = 1 (when flush = 0).
- Enqueue-to-dequeue latency: 1 cycle. An entry enqueued at edge k is presented at deq_* after edge k, i.e. during cycle k+1.
- Throughput: 1 enqueue and 1 dequeue per cycle sustained, when 0 < count < DEPTH.
- Full (count = DEPTH): enq_ready_F = 0; a dequeue that cycle gives count = DEPTH−1, and enq_ready_F = 1 the following cycle.
- Empty (count = 0): deq_valid_D = 0; deq_* values are don't-care.
- Flush with reset asserted in the same cycle: reset behaviour applies.
- Flush in cycle k: enq_ready_F and deq_valid_D are low during cycle k. The queue is empty after edge k. The first correct-path instruction can be enqueued in cycle k+1 and dequeued in cycle k+2.
- Pointers wrap from DEPTH−1 to 0 with no bubble.

## Test plan
- Reset: hold reset 2 cycles with enq_valid_F = 1 → count = 0, deq_valid_D = 0, deq_pc_D = 0, deq_instr_D = 0, and no entry is accepted.
- Fill/drain: with deq_ready_D = 0, enqueue PCs 0x0, 0x4, 0x8, 0xC → count = 4 and enq_ready_F = 0 during the 5th cycle. Then set deq_ready_D = 1 → decode sees PCs 0x0, 0x4, 0x8, 0xC in order on 4 consecutive cycles, with matching instruction words.
- Streaming/wrap: hold enq_valid_F = deq_ready_D = 1 for 20 cycles with PC stepping by 4 from 0x100 → each PC appears exactly once, 1 cycle after its enqueue, and count stays at 1. Covers pointer wrap several times.
- Full with simultaneous dequeue: count = 4, enq_valid_F = 1, deq_ready_D = 1 → no enqueue that cycle; count = 3 next cycle, enq_ready_F = 1.
- Flush: queue holds 0x200–0x20C and flush is pulsed 1 cycle while enq_valid_F = 1 (PC 0x210) → count = 0 next cycle and 0x210 is dropped. Then enqueue 0xD800 (exception vector) → it is the next PC seen by decode.
- Reset mid-operation: count = 3 and reset is asserted together with flush and enqueue → count = 0 and storage is zeroed the next cycle; normal operation resumes after reset is deasserted.
